// File: rtl/pipe_de_cond.sv
// Decode-to-execute pipeline register with ARM-style conditional execution.
// Holds the architectural NZCV flags and gates side effects on condition pass.
module pipe_de_cond #(
  parameter int WIDTH = 32,
  parameter int RADDR = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             PCSrcD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ALUControlD,
  input  logic [1:0]       FlagWriteD,
  input  logic [3:0]       CondD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ExtImmD,
  input  logic [RADDR-1:0] WA3D,
  input  logic [RADDR-1:0] RA1D,
  input  logic [RADDR-1:0] RA2D,
  input  logic [3:0]       ALUFlags,
  output logic             MemtoRegE,
  output logic             ALUSrcE,
  output logic             BranchE,
  output logic [1:0]       ALUControlE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] ExtImmE,
  output logic [RADDR-1:0] WA3E,
  output logic [RADDR-1:0] RA1E,
  output logic [RADDR-1:0] RA2E,
  output logic             ValidE,
  output logic             CondExE,
  output logic             PCSrcGE,
  output logic             RegWriteGE,
  output logic             MemWriteGE,
  output logic             BranchTakenE,
  output logic [3:0]       FlagsE
);

  logic       pcSrcE;
  logic       regWriteE;
  logic       memWriteE;
  logic [1:0] flagWriteE;
  logic [3:0] condE;
  logic       condPass;
  logic       n, z, c, v;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcSrcE      <= 1'b0;
      regWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      memWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      ALUControlE <= '0;
      flagWriteE  <= '0;
      condE       <= '0;
      ValidE      <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ExtImmE     <= '0;
      WA3E        <= '0;
      RA1E        <= '0;
      RA2E        <= '0;
    end else if (FlushE || !StallE) begin
      pcSrcE      <= PCSrcD & ~FlushE;
      regWriteE   <= RegWriteD & ~FlushE;
      MemtoRegE   <= MemtoRegD & ~FlushE;
      memWriteE   <= MemWriteD & ~FlushE;
      BranchE     <= BranchD & ~FlushE;
      ALUSrcE     <= ALUSrcD & ~FlushE;
      ALUControlE <= FlushE ? 2'b00 : ALUControlD;
      flagWriteE  <= FlushE ? 2'b00 : FlagWriteD;
      condE       <= FlushE ? 4'b0000 : CondD;
      ValidE      <= ~FlushE;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ExtImmE     <= ExtImmD;
      WA3E        <= WA3D;
      RA1E        <= RA1D;
      RA2E        <= RA2D;
    end
  end

  // Flags belong to the instruction already in E, so a flush still commits them.
  always_ff @(posedge clk) begin
    if (reset) begin
      FlagsE <= '0;
    end else if (!StallE && CondExE) begin
      if (flagWriteE[1]) FlagsE[3:2] <= ALUFlags[3:2];
      if (flagWriteE[0]) FlagsE[1:0] <= ALUFlags[1:0];
    end
  end

  assign {n, z, c, v} = FlagsE;

  always_comb begin
    condPass = 1'b0;
    unique case (condE)
      4'b0000: condPass = z;
      4'b0001: condPass = ~z;
      4'b0010: condPass = c;
      4'b0011: condPass = ~c;
      4'b0100: condPass = n;
      4'b0101: condPass = ~n;
      4'b0110: condPass = v;
      4'b0111: condPass = ~v;
      4'b1000: condPass = c & ~z;
      4'b1001: condPass = ~c | z;
      4'b1010: condPass = (n == v);
      4'b1011: condPass = (n != v);
      4'b1100: condPass = ~z & (n == v);
      4'b1101: condPass = z | (n != v);
      4'b1110: condPass = 1'b1;
      4'b1111: condPass = 1'b0;
    endcase
  end

  assign CondExE      = ValidE & condPass;
  assign PCSrcGE      = pcSrcE & CondExE;
  assign RegWriteGE   = regWriteE & CondExE;
  assign MemWriteGE   = memWriteE & CondExE;
  assign BranchTakenE = BranchE & CondExE;

endmodule

// File: doc/pipe_de_cond.md
PIPE_DE_COND -- requirements
Module: pipe_de_cond

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width of RD1/RD2/ExtImm.
REQ-002 SHALL have parameter RADDR, default 4, register-address width.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as follows:
 clk  in  1  clock; all state updates on rising edge
 reset  in  1  synchronous active-high reset
 StallE  in  1  hold E-stage contents
 FlushE  in  1  load a bubble into E stage
 PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  in  1 each  decode controls
 ALUControlD  in  2  ALU op
 FlagWriteD  in  2  [1]=update N,Z; [0]=update C,V
 CondD  in  4  ARM condition field
 RD1D, RD2D, ExtImmD  in  WIDTH each  operands
 WA3D, RA1D, RA2D  in  RADDR each  write/read register addresses
 ALUFlags  in  4  {N,Z,C,V} from E-stage ALU
 MemtoRegE, ALUSrcE, BranchE  out  1 each  registered controls
 ALUControlE  out  2  registered ALU op
 RD1E, RD2E, ExtImmE  out  WIDTH each  registered operands
 WA3E, RA1E, RA2E  out  RADDR each  registered addresses
 ValidE  out  1  E stage holds a real instruction
 CondExE  out  1  condition passes and ValidE=1
 PCSrcGE, RegWriteGE, MemWriteGE  out  1 each  controls gated by CondExE
 BranchTakenE  out  1  BranchE & CondExE
 FlagsE  out  4  architectural flag register {N,Z,C,V}

Function
REQ-004 SHALL, on rising edge with FlushE=0 and StallE=0, capture every D input into its E register and set ValidE=1.
REQ-005 SHALL, with StallE=1 and FlushE=0, hold all E registers and ValidE unchanged.
REQ-006 SHALL, with FlushE=1, clear all control registers (PCSrc, RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUControl, FlagWrite, Cond) and ValidE to 0; data/address registers may take D values.
REQ-007 SHALL give FlushE priority over StallE when both are 1.
REQ-008 SHALL evaluate condition combinationally from CondE and FlagsE: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
REQ-009 SHALL drive CondExE = ValidE & condition result.
REQ-010 SHALL drive PCSrcGE, RegWriteGE, MemWriteGE, BranchTakenE as respective E control AND CondExE.
REQ-011 SHALL update FlagsE[3:2] from ALUFlags[3:2] on an edge where CondExE=1, FlagWriteE[1]=1, StallE=0.
REQ-012 SHALL update FlagsE[1:0] from ALUFlags[1:0] on an edge where CondExE=1, FlagWriteE[0]=1, StallE=0.
REQ-013 SHALL leave FlagsE unchanged when StallE=1, CondExE=0, or the matching FlagWriteE bit is 0.
REQ-014 SHALL apply a flag update and a new capture on the same edge; the incoming instruction's condition sees the updated flags one cycle later.
REQ-015 SHALL apply flag update (REQ-011/012) on an edge with FlushE=1 and StallE=0, since flush affects only the incoming instruction.
REQ-016 SHALL produce all outputs directly from registers or REQ-008..010 logic; no D-input-to-output combinational path.

Reset
REQ-017 SHALL, on rising edge with reset=1, clear every E register, ValidE and FlagsE to 0, overriding StallE and FlushE.
REQ-018 SHALL hold CondExE and all gated outputs at 0 from the edge after reset until the first non-flushed capture.
REQ-019 SHALL resume normal capture on the first edge with reset=0.

Verification
REQ-020 SHALL cover reset: reset=1 one cycle with StallE=1 -> all outputs 0, FlagsE=0000.
REQ-021 SHALL cover capture: RegWriteD=1, CondD=1110, RD1D=0x12345678 -> next cycle RD1E=0x12345678, ValidE=1, RegWriteGE=1.
REQ-022 SHALL cover cond fail: FlagsE=0000, CondD=0000 (EQ), MemWriteD=1 -> MemWriteGE=0, CondExE=0; FlagsE unchanged despite FlagWriteD=11.
REQ-023 SHALL cover partial flag write: CondE=AL, FlagWriteE=10, ALUFlags=1111 -> FlagsE=1100 next cycle.
REQ-024 SHALL cover stall/flush: StallE=1 holds E 3 cycles, FlagsE constant; StallE=1 with FlushE=1 -> ValidE=0, all gated outputs 0.
REQ-025 SHALL cover back-to-back: CMP-like (FlagWrite=11, ALUFlags=0100) then BEQ (CondD=0000, BranchD=1) -> BranchTakenE=1 in BEQ's E cycle.
